present_ctr_feeder: RTL and testbench
=====================================

# present_ctr_feeder

Upstream feeder for the PRESENT-80 CTR decryption core. Accepts a byte stream of frames (8-byte IV, then ciphertext bytes) and packs the ciphertext into 64-bit blocks. It tracks the CTR counter itself and sequences the core's `load_IV` / `load` / `ciphertext` inputs on a fixed 33-cycle block period. It also emits a sideband strobe with byte count and last flag, aligned to the core's registered `plaintext` output.

## Interface
- `STAGE_BLOCKS`, default 1: number of complete ciphertext blocks buffered beyond the assembly register, legal range 1..2.
- `clk`, input, 1: clock; all logic is on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `s_valid`, input, 1: byte valid.
- `s_ready`, output, 1: byte accepted on an edge where `s_valid` and `s_ready` are both high.
- `s_data`, input, 8: stream byte.
- `s_last`, input, 1: final byte of the frame.
- `load_IV`, output, 1: core counter load strobe.
- `IV`, output, 64: counter value presented to the core.
- `load`, output, 1: core block start strobe.
- `ciphertext`, output, 64: block presented to the core.
- `load_decrypt`, input, 1: core round-0 flag; used only under the check macro.
- `pt_valid`, output, 1: the core's `plaintext` holds a finished block this cycle.
- `pt_nbytes`, output, 4: valid bytes in that block, 1..8, MSB-first.
- `pt_last`, output, 1: that block ends its frame.
- `frame_err`, output, 1: one-cycle pulse when `s_last` arrives during the IV bytes.

## Operation
- **Frame format:** bytes 0..7 form the IV, big-endian (byte 0 goes to [63:56]). Later bytes are ciphertext, packed MSB-first.
- **IV handling:** the IV is loaded into the 64-bit shadow counter `ctr`.
- **Counter advance:** `ctr` increments by 1 after each block is issued, modulo 2^64. All-ones wraps to 0.
- **Block completion:** a block completes on its 8th byte or on `s_last`.
- **Partial blocks:** unfilled low bytes are zero, and `nbytes` records the bytes received.
- **Short frames:** `s_last` on an IV byte discards the frame and pulses `frame_err`. `s_last` on IV byte 7 is a legal IV-only frame and issues no blocks.
- **Drift protection:** every block reloads the counter via `load_IV` before `load`. Counter drift inside the core from its free-running round counter during idle time therefore never matters.
- **FSM states:** IDLE, LDIV, LOAD, RUN, FIN.
  - IDLE → LDIV when a staged block exists.
  - LDIV: `load_IV`=1 and `IV`=`ctr`. The `ciphertext`, `nbytes` and `last` registers update from staging at the end of this cycle. → LOAD.
  - LOAD: `load`=1. → RUN.
  - RUN: a 5-bit timer counts 31 cycles. → FIN.
  - FIN (the core's round-0 cycle): `ciphertext` is held. If a block is staged, `load_IV` also asserts in this cycle (LDIV merged into FIN) → LOAD; otherwise → IDLE.
- **Sideband strobe:** `pt_valid` pulses in the cycle after FIN. `pt_nbytes` and `pt_last` are held until the next FIN.
- **Input flow control:** `s_ready` = assembly register not full, or a staging slot frees this cycle. Bytes are never dropped or reordered.
- **Reset values:** all outputs 0, `IV`/`ciphertext` 0, state IDLE, `s_ready` 1 in the first cycle after release.
- **Reset mid-block:** the block is abandoned, `pt_valid` does not assert for it, and partially assembled bytes are dropped. The core needs no reset because the next block reloads it.

## Timing
- 8th ciphertext byte accepted at edge n with the engine idle:
  - `load_IV` high in cycle n+1;
  - `load` high in n+2;
  - core round 0 in n+34;
  - `pt_valid` high in n+35.
- Back-to-back blocks: `load` strobes are exactly 33 cycles apart, and `pt_valid` strobes are 33 cycles apart.
- `ciphertext` is stable from the LOAD cycle through FIN inclusive.
- `load` and `load_IV` are never high in the same cycle. Each is at most one cycle wide.
- Simultaneous `s_last` and an 8th byte produce a full block with `nbytes`=8 and `last`=1.

## Configuration
- `PRESENT_CTR_CHECK_EN` defined: adds output `sync_err` (1 bit), which becomes sticky-1 until reset if `load_decrypt` differs from (state==FIN) in any cycle from the first LOAD onward.
- Not defined: no `sync_err` port, and `load_decrypt` is ignored.

## Structure
- **Package `present_ctr_pkg`:**
  - localparams `BLK_BYTES`=8 and `RUN_CYCLES`=31;
  - enum `feed_state_t` {IDLE, LDIV, LOAD, RUN, FIN};
  - struct `ct_blk_t` {data[63:0], nbytes[3:0], last}.
- **Sub-module `ct_byte_packer`:** byte assembly, zero padding, IV capture and `frame_err`. It outputs `ct_blk_t` with valid/ready to the staging buffer.

## Test plan
- **Reset:** assert `rst_n` low at random times → all outputs 0; `s_ready`=1 one cycle after release.
- **Two full blocks:** IV 0x0123456789ABCDEF + 16 bytes → `IV` values 0x0123456789ABCDEF then 0x0123456789ABCDF0; `load` strobes 33 apart; two `pt_valid`, the second with `pt_last`=1, `pt_nbytes`=8.
- **Partial block:** IV + 11 bytes → second `ciphertext` has low 5 bytes 0x00; `pt_nbytes`=3, `pt_last`=1.
- **Counter wrap:** IV 0xFFFFFFFFFFFFFFFF + 16 bytes → second `IV`=0.
- **Backpressure:** `s_valid` held high for a 64-byte frame → `s_ready` drops while staging is full; the `ciphertext` sequence matches the input order exactly.
- **Reset mid-RUN and short frame:** reset at RUN cycle 10 → no `pt_valid`, and the following frame decodes correctly; `s_last` on IV byte 3 → `frame_err` pulse and no `load`.
  - With `PRESENT_CTR_CHECK_EN`, forcing `load_decrypt` high in RUN → `sync_err`=1.

Source files
------------

// File: rtl/present_ctr_pkg.sv
// Shared constants and types for the PRESENT-80 CTR feeder and its byte packer.
package present_ctr_pkg;

  localparam int BLK_BYTES  = 8;
  localparam int RUN_CYCLES = 31;

  typedef enum logic [2:0] {IDLE, LDIV, LOAD, RUN, FIN} feed_state_t;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  nbytes;
    logic        last;
  } ct_blk_t;

endpackage

// File: rtl/present_ctr_feeder_packer.sv
// Byte packer: captures the 8-byte IV, packs ciphertext MSB-first into zero-padded blocks,
// and holds one completed block when the staging buffer cannot take it.
module ct_byte_packer
  import present_ctr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid_i,
  input  logic [7:0]  s_data_i,
  input  logic        s_last_i,
  output logic        s_ready_o,
  input  logic        iv_ok_i,
  output logic        iv_load_o,
  output logic [63:0] iv_o,
  output logic        frame_err_o,
  output logic        blk_valid_o,
  output ct_blk_t     blk_o,
  input  logic        blk_ready_i
);

  logic        in_iv_q, in_iv_d;
  logic [2:0]  idx_q, idx_d;
  logic [55:0] iv_q, iv_d;
  logic [63:0] asm_q, asm_d;
  logic [2:0]  cnt_q, cnt_d;
  ct_blk_t     held_q, held_d;
  logic        held_vld_q, held_vld_d;

  logic        iv_last, accept, ct_acc, completes;
  ct_blk_t     new_blk;

  always_comb begin
    iv_last = in_iv_q && (idx_q == 3'd7);
    // The final IV byte overwrites the shared counter, so it waits until no older block needs it
    if (in_iv_q) s_ready_o = !iv_last || (iv_ok_i && !held_vld_q);
    else         s_ready_o = !held_vld_q || blk_ready_i;
    accept    = s_valid_i && s_ready_o;
    ct_acc    = accept && !in_iv_q;
    completes = ct_acc && (s_last_i || (cnt_q == 3'(BLK_BYTES - 1)));

    new_blk.data   = asm_q | ({s_data_i, 56'd0} >> {cnt_q, 3'b000});
    new_blk.nbytes = {1'b0, cnt_q} + 4'd1;
    new_blk.last   = s_last_i;

    blk_valid_o = held_vld_q || completes;
    blk_o       = held_vld_q ? held_q : new_blk;
    iv_o        = {iv_q, s_data_i};

    in_iv_d     = in_iv_q;
    idx_d       = idx_q;
    iv_d        = iv_q;
    asm_d       = asm_q;
    cnt_d       = cnt_q;
    held_d      = held_q;
    held_vld_d  = held_vld_q;
    iv_load_o   = 1'b0;
    frame_err_o = 1'b0;

    if (accept && in_iv_q) begin
      iv_d  = {iv_q[47:0], s_data_i};
      idx_d = idx_q + 3'd1;
      if (iv_last) begin
        iv_load_o = 1'b1;
        in_iv_d   = s_last_i;
      end else if (s_last_i) begin
        frame_err_o = 1'b1;
        idx_d       = 3'd0;
      end
    end

    if (ct_acc) begin
      if (completes) begin
        asm_d   = '0;
        cnt_d   = 3'd0;
        in_iv_d = s_last_i;
      end else begin
        asm_d = new_blk.data;
        cnt_d = cnt_q + 3'd1;
      end
    end

    if (held_vld_q && blk_ready_i) held_vld_d = 1'b0;
    if (completes && (held_vld_q || !blk_ready_i)) begin
      held_d     = new_blk;
      held_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_iv_q    <= 1'b1;
      idx_q      <= 3'd0;
      asm_q      <= '0;
      cnt_q      <= 3'd0;
      held_vld_q <= 1'b0;
    end else begin
      in_iv_q    <= in_iv_d;
      idx_q      <= idx_d;
      asm_q      <= asm_d;
      cnt_q      <= cnt_d;
      held_vld_q <= held_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    iv_q   <= iv_d;
    held_q <= held_d;
  end

endmodule

// File: rtl/present_ctr_feeder.sv
// Feeder for the PRESENT-80 CTR core: stages packed blocks and runs the 33-cycle issue FSM.
// Optional PRESENT_CTR_CHECK_EN adds sync_err, comparing load_decrypt against the FIN state.
module present_ctr_feeder
  import present_ctr_pkg::*;
#(
  parameter int STAGE_BLOCKS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        load_IV,
  output logic [63:0] IV,
  output logic        load,
  output logic [63:0] ciphertext,
  input  logic        load_decrypt,
  output logic        pt_valid,
  output logic [3:0]  pt_nbytes,
  output logic        pt_last,
  output logic        frame_err
`ifdef PRESENT_CTR_CHECK_EN
  ,
  output logic        sync_err
`endif
);

  feed_state_t state_q, state_d;
  logic [4:0]  timer_q, timer_d;
  ct_blk_t     stg_q [2];
  logic [1:0]  stg_cnt_q, stg_cnt_d;
  logic [63:0] ctr_q, ctr_d;
  logic [63:0] ct_q;
  logic [3:0]  cur_nb_q, pt_nb_q;
  logic        cur_last_q, pt_last_q, pt_valid_q;

  logic        blk_valid, blk_ready, push, pop, iv_load;
  logic [63:0] iv_val;
  logic        wr_idx;
  ct_blk_t     blk;

  ct_byte_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid_i   (s_valid),
    .s_data_i    (s_data),
    .s_last_i    (s_last),
    .s_ready_o   (s_ready),
    .iv_ok_i     (stg_cnt_q == 2'd0),
    .iv_load_o   (iv_load),
    .iv_o        (iv_val),
    .frame_err_o (frame_err),
    .blk_valid_o (blk_valid),
    .blk_o       (blk),
    .blk_ready_i (blk_ready)
  );

  // A block leaves staging in LDIV, or in FIN when the reload is merged into round 0
  assign pop       = (state_q == LDIV) || ((state_q == FIN) && (stg_cnt_q != 2'd0));
  assign load_IV   = pop;
  assign blk_ready = (stg_cnt_q < 2'(STAGE_BLOCKS)) || pop;
  assign push      = blk_valid && blk_ready;
  assign stg_cnt_d = stg_cnt_q + 2'(push) - 2'(pop);
  assign wr_idx    = pop ? stg_cnt_q[0] ^ 1'b1 : stg_cnt_q[0];
  assign ctr_d     = iv_load ? iv_val : (pop ? ctr_q + 64'd1 : ctr_q);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: if ((stg_cnt_q != 2'd0) || push) state_d = LDIV;
      LDIV: state_d = LOAD;
      LOAD: begin
        load    = 1'b1;
        timer_d = 5'd0;
        state_d = RUN;
      end
      RUN: begin
        timer_d = timer_q + 5'd1;
        if (timer_q == 5'(RUN_CYCLES - 1)) state_d = FIN;
      end
      FIN:     state_d = (stg_cnt_q != 2'd0) ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      timer_q    <= 5'd0;
      stg_cnt_q  <= 2'd0;
      ctr_q      <= '0;
      ct_q       <= '0;
      pt_valid_q <= 1'b0;
      pt_nb_q    <= 4'd0;
      pt_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      stg_cnt_q  <= stg_cnt_d;
      ctr_q      <= ctr_d;
      pt_valid_q <= (state_q == FIN);
      if (pop) ct_q <= stg_q[0].data;
      if (state_q == FIN) begin
        pt_nb_q   <= cur_nb_q;
        pt_last_q <= cur_last_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      stg_q[0]   <= stg_q[1];
      cur_nb_q   <= stg_q[0].nbytes;
      cur_last_q <= stg_q[0].last;
    end
    if (push) stg_q[wr_idx] <= blk;
  end

  assign IV         = ctr_q;
  assign ciphertext = ct_q;
  assign pt_valid   = pt_valid_q;
  assign pt_nbytes  = pt_nb_q;
  assign pt_last    = pt_last_q;

`ifdef PRESENT_CTR_CHECK_EN
  logic armed_q, armed_d, sync_err_q, sync_err_d;
  assign armed_d    = armed_q || (state_q == LOAD);
  assign sync_err_d = sync_err_q || (armed_d && (load_decrypt != (state_q == FIN)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q    <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      armed_q    <= armed_d;
      sync_err_q <= sync_err_d;
    end
  end
  assign sync_err = sync_err_q;
`else
  logic unused_load_decrypt;
  assign unused_load_decrypt = load_decrypt;
`endif

endmodule

// File: tb/tb_present_ctr_feeder.sv
// Directed bench for present_ctr_feeder: frames in, strobes/values logged at negedge and compared.
module tb_present_ctr_feeder;

  logic        clk = 1'b0;
  logic        rst_n, s_valid, s_ready, s_last, load_IV, load, load_decrypt;
  logic        pt_valid, pt_last, frame_err;
  logic [7:0]  s_data;
  logic [63:0] IV, ciphertext;
  logic [3:0]  pt_nbytes;
`ifdef PRESENT_CTR_CHECK_EN
  logic        sync_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc8     = 0;

  present_ctr_feeder #(.STAGE_BLOCKS(1)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .load_IV(load_IV), .IV(IV), .load(load), .ciphertext(ciphertext),
    .load_decrypt(load_decrypt), .pt_valid(pt_valid), .pt_nbytes(pt_nbytes),
    .pt_last(pt_last), .frame_err(frame_err)
`ifdef PRESENT_CTR_CHECK_EN
    , .sync_err(sync_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log, sampled on the falling edge
  logic [63:0] liv_iv[$], ld_ct[$];
  int          liv_cyc[$], ld_cyc[$], pv_cyc[$];
  logic [3:0]  pv_nb[$];
  logic        pv_last[$];
  int          fe_cnt, both_cnt, stab_cnt;
  bit          stall_seen, track;
  logic [63:0] hold_ct;

  always @(negedge clk) begin
    if (!rst_n) begin
      track = 1'b0;
    end else begin
      if (load_IV) begin liv_iv.push_back(IV); liv_cyc.push_back(cyc); end
      if (load) begin ld_ct.push_back(ciphertext); ld_cyc.push_back(cyc); end
      if (pt_valid) begin
        pv_cyc.push_back(cyc); pv_nb.push_back(pt_nbytes); pv_last.push_back(pt_last);
      end
      if (frame_err) fe_cnt++;
      if (load && load_IV) both_cnt++;
      if (s_valid && !s_ready) stall_seen = 1'b1;
      if (track && !pt_valid && (ciphertext !== hold_ct)) stab_cnt++;
      if (pt_valid) track = 1'b0;
      if (load) begin track = 1'b1; hold_ct = ciphertext; end
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    liv_iv.delete(); ld_ct.delete(); liv_cyc.delete(); ld_cyc.delete();
    pv_cyc.delete(); pv_nb.delete(); pv_last.delete();
    fe_cnt = 0; stall_seen = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge; returns 1 unit after the accepting edge
  task automatic send_byte(input logic [7:0] d, input logic l);
    bit ok;
    int guard;
    s_valid = 1'b1; s_data = d; s_last = l;
    ok = 1'b0; guard = 0;
    while (!ok && guard < 300) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!ok) check_val("s_ready_timeout", 0, 1);
  endtask

  task automatic send_frame(input logic [63:0] iv, input int n, input logic [7:0] base);
    for (int i = 0; i < 8; i++) send_byte(iv[63-8*i -: 8], (n == 0) && (i == 7));
    for (int i = 0; i < n; i++) begin
      send_byte(base + 8'(i), i == n - 1);
      if (i == 7) acc8 = cyc;
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_ctl"}, {load_IV, load, pt_valid, pt_last, frame_err}, 5'b0);
    check_val({tag, "_iv"}, IV, 64'd0);
    check_val({tag, "_ct"}, ciphertext, 64'd0);
    check_val({tag, "_nb"}, pt_nbytes, 4'd0);
  endtask

  initial begin
    logic [63:0] exp;
    int g;
    rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; load_decrypt = 1'b0;
    both_cnt = 0; stab_cnt = 0; track = 1'b0;
    clear_log();

    // Reset state
    wait_cycles($urandom_range(2, 6));
    @(negedge clk);
    check_idle_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_ready", s_ready, 1);
    @(posedge clk); #1;

    // Two full blocks
    clear_log();
    send_frame(64'h0123456789ABCDEF, 16, 8'h10);
    wait_cycles(90);
    check_val("two_nload", ld_ct.size(), 2);
    check_val("two_iv0", liv_iv[0], 64'h0123456789ABCDEF);
    check_val("two_iv1", liv_iv[1], 64'h0123456789ABCDF0);
    check_val("two_ct0", ld_ct[0], 64'h1011121314151617);
    check_val("two_ct1", ld_ct[1], 64'h18191A1B1C1D1E1F);
    check_val("two_livlat", liv_cyc[0] - acc8, 0);
    check_val("two_ldlat", ld_cyc[0] - acc8, 1);
    check_val("two_pvlat", pv_cyc[0] - acc8, 34);
    check_val("two_ldgap", ld_cyc[1] - ld_cyc[0], 33);
    check_val("two_npv", pv_cyc.size(), 2);
    check_val("two_pvgap", pv_cyc[1] - pv_cyc[0], 33);
    check_val("two_pv0", {pv_nb[0], pv_last[0]}, {4'd8, 1'b0});
    check_val("two_pv1", {pv_nb[1], pv_last[1]}, {4'd8, 1'b1});

    // Partial final block
    clear_log();
    send_frame(64'h1111111111111111, 11, 8'h20);
    wait_cycles(90);
    check_val("part_nload", ld_ct.size(), 2);
    check_val("part_ct1", ld_ct[1], 64'h28292A0000000000);
    check_val("part_pv0", {pv_nb[0], pv_last[0]}, {4'd8, 1'b0});
    check_val("part_pv1", {pv_nb[1], pv_last[1]}, {4'd3, 1'b1});

    // Counter wrap
    clear_log();
    send_frame(64'hFFFFFFFFFFFFFFFF, 16, 8'h50);
    wait_cycles(90);
    check_val("wrap_nliv", liv_iv.size(), 2);
    check_val("wrap_iv0", liv_iv[0], 64'hFFFFFFFFFFFFFFFF);
    check_val("wrap_iv1", liv_iv[1], 64'd0);

    // Backpressure over a 64-byte frame
    clear_log();
    send_frame(64'h00000000000000FE, 64, 8'h40);
    wait_cycles(140);
    check_val("bp_stall", stall_seen, 1);
    check_val("bp_nload", ld_ct.size(), 8);
    for (int k = 0; k < 8; k++) begin
      exp = '0;
      for (int j = 0; j < 8; j++) exp = {exp[55:0], 8'h40 + 8'(8 * k + j)};
      check_val($sformatf("bp_ct%0d", k), ld_ct[k], exp);
      if (k > 0) check_val($sformatf("bp_gap%0d", k), ld_cyc[k] - ld_cyc[k-1], 33);
    end
    check_val("bp_iv7", liv_iv[7], 64'h0000000000000105);
    check_val("bp_last", {pv_cyc.size(), pv_last[7]}, {32'd8, 1'b1});

    // Reset in the middle of RUN
    clear_log();
    send_frame(64'h0F0F0F0F0F0F0F0F, 8, 8'h60);
    g = 0;
    while (ld_ct.size() == 0 && g < 60) begin wait_cycles(1); g++; end
    check_val("mid_load_seen", ld_ct.size(), 1);
    wait_cycles(10);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_rst");
    wait_cycles($urandom_range(1, 4));
    rst_n = 1'b1;
    @(negedge clk);
    check_val("mid_ready", s_ready, 1);
    @(posedge clk); #1;
    clear_log();
    wait_cycles(50);
    check_val("mid_nopv", pv_cyc.size() + ld_ct.size(), 0);
    send_frame(64'hA5A5A5A5A5A5A5A5, 8, 8'h30);
    wait_cycles(50);
    check_val("mid_ct", ld_ct[0], 64'h3031323334353637);
    check_val("mid_iv", liv_iv[0], 64'hA5A5A5A5A5A5A5A5);
    check_val("mid_pv", {pv_cyc.size(), pv_nb[0], pv_last[0]}, {32'd1, 4'd8, 1'b1});

    // Short frame, IV-only frame, then a one-byte frame
    clear_log();
    for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i), i == 3);
    s_valid = 1'b0; s_last = 1'b0;
    wait_cycles(40);
    check_val("short_ferr", fe_cnt, 1);
    check_val("short_noload", ld_ct.size() + liv_iv.size(), 0);
    send_frame(64'h2222222222222222, 0, 8'h00);
    wait_cycles(40);
    check_val("ivonly_quiet", fe_cnt + ld_ct.size() + liv_iv.size(), 1);
    send_frame(64'h0000000000000001, 1, 8'h77);
    wait_cycles(50);
    check_val("one_ct", ld_ct[0], 64'h7700000000000000);
    check_val("one_iv", liv_iv[0], 64'h0000000000000001);
    check_val("one_pv", {pv_cyc.size(), pv_nb[0], pv_last[0]}, {32'd1, 4'd1, 1'b1});

    check_val("never_both", both_cnt, 0);
    check_val("ct_stable", stab_cnt, 0);

`ifdef PRESENT_CTR_CHECK_EN
    clear_log();
    send_frame(64'h3333333333333333, 8, 8'h90);
    g = 0;
    while (ld_ct.size() == 0 && g < 60) begin wait_cycles(1); g++; end
    wait_cycles(4);
    load_decrypt = 1'b1;
    wait_cycles(1);
    load_decrypt = 1'b0;
    @(negedge clk);
    check_val("sync_err", sync_err, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
